// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_t;

  // Injected by the pipeline into IF/ID while a fetch is stalled
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned TMO_W    = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store, data first,
// with a fetch-starvation guard and a bounded wait on the memory handshake.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              stall_if,
  output logic              stall_mem
);

  state_t              state, state_n;
  src_t                src, src_n;
  logic [STARVE_W-1:0] starve_cnt, starve_cnt_n;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_n;
  logic                mem_req_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic [DATA_W-1:0]   if_rdata_n, d_rdata_n, resp_data;
  logic                if_ready_n, d_ready_n, err_n;
  logic                grant_if;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= SRC_IF;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      starve_cnt <= starve_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      if_rdata   <= if_rdata_n;
      d_rdata    <= d_rdata_n;
      if_ready   <= if_ready_n;
      d_ready    <= d_ready_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    src_n        = src;
    starve_cnt_n = starve_cnt;
    tmo_cnt_n    = tmo_cnt;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    if_rdata_n   = if_rdata;
    d_rdata_n    = d_rdata;
    if_ready_n   = 1'b0;
    d_ready_n    = 1'b0;
    err_n        = 1'b0;
    resp_data    = '0;
    grant_if     = 1'b0;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          // Fetch wins only when alone or when it has waited out STARVE_LIMIT data grants
          grant_if  = if_req && (!d_req || starve_cnt == STARVE_W'(STARVE_LIMIT));
          mem_req_n = 1'b1;
          tmo_cnt_n = '0;
          state_n   = BUSY;
          if (grant_if) begin
            src_n        = SRC_IF;
            mem_addr_n   = if_addr;
            mem_we_n     = 1'b0;
            mem_wdata_n  = '0;
            starve_cnt_n = '0;
          end else begin
            src_n       = SRC_D;
            mem_addr_n  = d_addr;
            mem_we_n    = d_we;
            mem_wdata_n = d_wdata;
            if (if_req && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
              starve_cnt_n = STARVE_W'(starve_cnt + 1'b1);
            end
          end
        end
      end

      BUSY: begin
        // An ack on the last allowed cycle still counts as a clean completion
        if (mem_ack || tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          resp_data = (mem_ack && !mem_we) ? mem_rdata : '0;
          err_n     = ~mem_ack;
          mem_req_n = 1'b0;
          state_n   = RESP;
          if (src == SRC_D) begin
            d_rdata_n = resp_data;
            d_ready_n = 1'b1;
          end else begin
            if_rdata_n = resp_data;
            if_ready_n = 1'b1;
          end
        end else begin
          tmo_cnt_n = TMO_W'(tmo_cnt + 1'b1);
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level model of grant order,
// access timing, timeouts and returned data, plus an asynchronous reset mid-access.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_ready, d_req, d_we, d_ready;
  logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic              mem_req, mem_we, mem_ack, err, stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: one outstanding access described by its grant cycle and completion cycle
  bit                busy = 1'b0;
  bit                g_is_d, g_err;
  int                g_cyc, ack_cyc, end_cyc;
  logic [ADDR_W-1:0] x_addr;
  logic              x_we;
  logic [DATA_W-1:0] x_wdata, ack_data;
  logic [DATA_W-1:0] x_if_rdata = '0;
  logic [DATA_W-1:0] x_d_rdata = '0;
  int                run_data = 0;
  bit                if_pend = 1'b0, d_pend = 1'b0, if_rel = 1'b0, d_rel = 1'b0;
  int                p_if, p_d;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all_zero();
    check_eq("rst_mem_req", 64'(mem_req), 64'(0));
    check_eq("rst_mem_we", 64'(mem_we), 64'(0));
    check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check_eq("rst_if_rdata", 64'(if_rdata), 64'(0));
    check_eq("rst_d_rdata", 64'(d_rdata), 64'(0));
    check_eq("rst_if_ready", 64'(if_ready), 64'(0));
    check_eq("rst_d_ready", 64'(d_ready), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
  endtask

  // One cycle: requesters and memory drive, model predicts, outputs compared
  task automatic step_body();
    bit x_mreq, x_ifr, x_dr, x_err;
    int lat, r;
    if (if_rel) begin if_pend = 1'b0; if_rel = 1'b0; end
    if (d_rel) begin d_pend = 1'b0; d_rel = 1'b0; end
    if (!if_pend && int'($urandom_range(99)) < p_if) begin
      if_pend = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!d_pend && int'($urandom_range(99)) < p_d) begin
      d_pend  = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if_req = if_pend;
    d_req  = d_pend;

    if (busy && cyc > end_cyc) busy = 1'b0;
    if (busy && cyc > g_cyc && cyc < end_cyc) begin
      mem_ack   = (cyc == ack_cyc);
      mem_rdata = (cyc == ack_cyc) ? ack_data : $urandom;
    end else begin
      mem_ack   = ($urandom_range(3) == 0);
      mem_rdata = $urandom;
    end

    x_mreq = busy && cyc > g_cyc && cyc < end_cyc;
    x_ifr  = busy && cyc == end_cyc && !g_is_d;
    x_dr   = busy && cyc == end_cyc && g_is_d;
    x_err  = busy && cyc == end_cyc && g_err;
    if (x_ifr) begin x_if_rdata = g_err ? '0 : ack_data; if_rel = 1'b1; end
    if (x_dr) begin x_d_rdata = (g_err || x_we) ? '0 : ack_data; d_rel = 1'b1; end

    if (!busy && (if_pend || d_pend)) begin
      g_is_d = d_pend && !(if_pend && run_data >= STARVE_LIMIT);
      if (g_is_d) begin
        x_addr = d_addr; x_we = d_we; x_wdata = d_wdata;
        if (if_pend && run_data < STARVE_LIMIT) run_data++;
      end else begin
        x_addr = if_addr; x_we = 1'b0; x_wdata = '0;
        run_data = 0;
      end
      r = int'($urandom_range(19));
      if (r < 12)      lat = 1 + int'($urandom_range(2));
      else if (r < 16) lat = 4 + int'($urandom_range(7));
      else if (r < 18) lat = TIMEOUT;
      else             lat = 0;
      busy  = 1'b1;
      g_cyc = cyc;
      if (lat > 0) begin
        ack_cyc = cyc + lat; end_cyc = cyc + lat + 1; g_err = 1'b0; ack_data = $urandom;
      end else begin
        ack_cyc = -1; end_cyc = cyc + TIMEOUT + 1; g_err = 1'b1;
      end
    end

    #1;
    check_eq("mem_req", 64'(mem_req), 64'(x_mreq));
    check_eq("if_ready", 64'(if_ready), 64'(x_ifr));
    check_eq("d_ready", 64'(d_ready), 64'(x_dr));
    check_eq("err", 64'(err), 64'(x_err));
    check_eq("if_rdata", 64'(if_rdata), 64'(x_if_rdata));
    check_eq("d_rdata", 64'(d_rdata), 64'(x_d_rdata));
    check_eq("stall_if", 64'(stall_if), 64'(if_req && !x_ifr));
    check_eq("stall_mem", 64'(stall_mem), 64'(d_req && !x_dr));
    if (x_mreq) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(x_addr));
      check_eq("mem_we", 64'(mem_we), 64'(x_we));
      if (x_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(x_wdata));
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_body();
  endtask

  task automatic run(input int n, input int pi, input int pd);
    p_if = pi;
    p_d  = pd;
    for (int i = 0; i < n; i++) step();
  endtask

  // Catch a data access mid-flight, reset it, and expect a fresh grant afterwards
  task automatic reset_mid_busy();
    bit found = 1'b0;
    p_if = 0;
    p_d  = 100;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (busy && g_is_d && (cyc - 1) > g_cyc && (cyc - 1) < end_cyc) found = 1'b1;
    end
    check_eq("reset_setup_found", 64'(found), 64'(1));
    if (found) begin
      @(negedge clk);
      mem_ack = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("async_mem_req", 64'(mem_req), 64'(0));
      check_eq("async_d_ready", 64'(d_ready), 64'(0));
      check_eq("async_err", 64'(err), 64'(0));
      @(posedge clk);
      #1;
      check_all_zero();
      busy = 1'b0; run_data = 0; x_if_rdata = '0; x_d_rdata = '0;
      if_rel = 1'b0; d_rel = 1'b0;
      rst = 1'b0;
      step_body();
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    p_if = 0; p_d = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero();
    rst = 1'b0;
    step_body();

    run(500, 30, 30);
    run(500, 100, 100);
    run(200, 100, 0);
    run(200, 0, 100);
    run(400, 60, 60);
    reset_mid_busy();
    run(300, 50, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
